// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Shared opcodes, result width and bridge state encodings for the
//          byte-serial floating-point ALU and its host bridge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;

  localparam int ALU_BYTES = 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_SEND    = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_COLLECT = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

endpackage

`default_nettype wire

// File: rtl/alu_host_bridge.sv
// ============================================================================
// Module : alu_host_bridge
// Brief  : Serialises a 32-bit operand pair onto the byte-wide ALU port and
//          reassembles the 4-byte result, with done-timeout recovery.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_host_bridge
  import alu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [1:0]  req_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_timeout,
  output logic [7:0]  alu_in,
  output logic [1:0]  alu_opcode,
  output logic        alu_start,
  input  logic [7:0]  alu_out,
  input  logic        alu_done,
  output logic        alu_rst_n
);

  localparam int              c_CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(TIMEOUT - 1);
  localparam logic [2:0]      c_RES_LAST = 3'(ALU_BYTES - 1);

  logic [2:0]      r_state;
  logic [63:0]     r_ops;       // {b, a}: byte k of the stream is r_ops[8k +: 8]
  logic [2:0]      r_idx;
  logic [c_CW-1:0] r_cnt;
  logic [23:0]     r_res;
  logic            r_done_q;
  logic            r_to_pulse;
  logic            r_rsp_valid;
  logic            r_rsp_timeout;
  logic [31:0]     r_rsp_result;
  logic [7:0]      r_alu_in;
  logic [1:0]      r_alu_opcode;
  logic            r_alu_start;

  logic [2:0]      w_next_idx;
  logic [7:0]      w_next_byte;

  assign w_next_idx  = r_idx + 3'd1;
  assign w_next_byte = r_ops[{w_next_idx, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ops         <= '0;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_res         <= '0;
      r_done_q      <= 1'b0;
      r_to_pulse    <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_result  <= '0;
      r_alu_in      <= '0;
      r_alu_opcode  <= '0;
      r_alu_start   <= 1'b0;
    end else begin
      r_done_q   <= alu_done;
      r_to_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_ops        <= {req_b, req_a};
            r_alu_opcode <= req_op;
            r_alu_start  <= 1'b1;
            r_state      <= S_START;
          end
        end
        S_START: begin
          r_alu_start <= 1'b0;
          r_alu_in    <= r_ops[7:0];
          r_idx       <= 3'd0;
          r_state     <= S_SEND;
        end
        S_SEND: begin
          // Last byte stays on the bus; no wrap back to a[7:0].
          if (r_idx == 3'd7) begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end else begin
            r_idx    <= w_next_idx;
            r_alu_in <= w_next_byte;
          end
        end
        S_WAIT: begin
          if (alu_done && !r_done_q) begin
            r_res[7:0] <= alu_out;
            r_idx      <= 3'd1;
            r_state    <= S_COLLECT;
          end else if (r_cnt == c_CNT_LAST) begin
            r_rsp_timeout <= 1'b1;
            r_rsp_result  <= '0;
            r_rsp_valid   <= 1'b1;
            r_to_pulse    <= 1'b1;
            r_state       <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_COLLECT: begin
          if (r_idx == c_RES_LAST) begin
            r_rsp_result <= {alu_out, r_res};
            r_rsp_valid  <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            case (r_idx[1:0])
              2'd1:    r_res[15:8]  <= alu_out;
              2'd2:    r_res[23:16] <= alu_out;
              default: r_res[7:0]   <= alu_out;
            endcase
            r_idx <= w_next_idx;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = (r_state == S_IDLE) & ~rst;
  assign alu_rst_n   = ~(rst | r_to_pulse);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_timeout = r_rsp_timeout;
  assign rsp_result  = r_rsp_result;
  assign alu_in      = r_alu_in;
  assign alu_opcode  = r_alu_opcode;
  assign alu_start   = r_alu_start;

endmodule

`default_nettype wire

// File: doc/alu_host_bridge.md
# alu_host_bridge

Host-side sequencer for the byte-serial floating-point ALU. Accepts a full 32-bit operand pair and opcode on a valid/ready request port. Drives the ALU's start / 8-bit operand stream, then reassembles the four result bytes. Returns the 32-bit result on a valid/ready response port, with timeout recovery if the ALU never signals done.

## Interface
- `TIMEOUT`, default 16: cycles allowed in S_WAIT for `alu_done`; minimum 4.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request valid.
- `req_ready`  out  1  request accepted when `req_valid` and `req_ready` are high at a rising edge.
- `req_a`  in  32  operand A (IEEE-754 single).
- `req_b`  in  32  operand B.
- `req_op`  in  2  opcode: 00 add, 01 sub.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumed when `rsp_valid` and `rsp_ready` are high.
- `rsp_result`  out  32  reassembled result.
- `rsp_timeout`  out  1  response is a timeout; `rsp_result` = 0.
- `alu_in`  out  8  operand byte to ALU.
- `alu_opcode`  out  2  opcode to ALU.
- `alu_start`  out  1  start request to ALU.
- `alu_out`  in  8  result byte from ALU.
- `alu_done`  in  1  ALU done flag.
- `alu_rst_n`  out  1  active-low ALU reset; = ~(`rst` | `to_pulse`), where `to_pulse` is a registered one-cycle timeout flag.

## Operation
- States:
  - S_IDLE: `req_ready` = 1 (gated 0 while `rst`).
  - On accept: latch a/b/op; `alu_opcode` <= op; `alu_start` <= 1; go to S_START.
- S_START: one cycle; at the next edge `alu_start` <= 0, `alu_in` <= a[7:0], idx <= 0, go to S_SEND.
- S_SEND: each edge idx++ and `alu_in` <= next byte. Byte order is a[7:0], a[15:8], a[23:16], a[31:24], b[7:0] … b[31:24]. At the edge where idx == 7, go to S_WAIT with cnt <= 0.
- S_WAIT:
  - On the first edge with `alu_done` = 1 and `done_q` = 0 (rising detect): res[7:0] <= `alu_out`, idx <= 1, go to S_COLLECT.
  - Otherwise cnt++. If cnt == TIMEOUT-1 with no done: `rsp_timeout` <= 1, `rsp_result` <= 0, `to_pulse` <= 1, go to S_RESP.
- S_COLLECT: capture `alu_out` into res byte idx at each edge, LSB first. After byte 3, `rsp_result` <= res, `rsp_valid` <= 1, go to S_RESP.
- S_RESP: hold `rsp_valid` and data stable until `rsp_ready`. On handshake clear `rsp_valid` / `rsp_timeout` and go to S_IDLE.
- `alu_opcode` is held constant from accept until the response handshake.
- Reset values: state S_IDLE, `req_ready` 0 during `rst`, `rsp_valid` 0, `rsp_result` 0, `rsp_timeout` 0, `alu_start` 0, `alu_in` 0, `alu_opcode` 0, `alu_rst_n` 0 while `rst` high, `done_q` 0, `to_pulse` 0.
- Reset mid-operation: everything aborts and the ALU is reset through `alu_rst_n`. No response is emitted for the in-flight request.
- `req_valid` is ignored outside S_IDLE. `alu_done` is ignored outside S_WAIT/S_COLLECT.

## Timing
- Request accepted at edge T:
  - `alu_start` high during cycle (T, T+1].
  - ALU samples start at T+1.
  - Operand bytes are presented after T+1 … T+8; the ALU samples them at T+2 … T+9.
- Done seen at T+12. Result bytes are captured at T+12, T+13, T+14, T+15.
- `rsp_valid` is high after T+15; this is the fixed latency of 15 cycles.
- With `rsp_ready` tied high: response handshake at T+16, `req_ready` high after T+16, next accept at T+17. This gives 1 op per 17 cycles.
- Timeout fires TIMEOUT cycles after S_WAIT entry. `alu_rst_n` is low for exactly 1 cycle, coincident with the first cycle of `rsp_valid`.

## Structure
- Shared package `alu_pkg` holds:
  - opcode constants OP_ADD = 2'b00, OP_SUB = 2'b01;
  - ALU_BYTES = 4;
  - bridge state encodings S_IDLE … S_RESP (3 bits).
- Single module with no sub-module. Byte select and collect are indexed muxes on idx; the timeout counter is inline and sized by $clog2(TIMEOUT).

## Test plan
Each scenario uses the real ALU as the DUT load.
- Add: a = 0x3FC00000 (1.5), b = 0x40100000 (2.25), op = 00 -> `rsp_result` 0x40700000, `rsp_timeout` 0, `rsp_valid` exactly 15 cycles after accept.
- Sub, back-to-back: a = 0x40700000, b = 0x3F800000, op = 01, immediately followed by a = 0x3F800000, b = 0x3F800000, op = 00 -> 0x40300000, then 0x40000000; second accept exactly 17 cycles after the first.
- Backpressure: hold `rsp_ready` = 0 for 10 cycles -> `rsp_valid` and `rsp_result` stable, `req_ready` 0, no ALU activity. Release -> one handshake only.
- Timeout: `alu_done` forced 0 -> after TIMEOUT cycles in S_WAIT, `rsp_valid` 1, `rsp_timeout` 1, `rsp_result` 0, `alu_rst_n` low 1 cycle. The next request completes normally.
- Reset mid-send: `rst` high for 1 cycle at T+5 -> no response, `alu_rst_n` low that cycle, all outputs at reset values. A fresh request returns the correct result.
- Wire monitor: `alu_in` byte sequence equals a[7:0] … b[31:24], and `alu_opcode` is constant over the whole operation.
